// File: rtl/radial_cfg_pkg.sv
// Shared types and reset constants for the radial zone configuration controller.
package radial_cfg_pkg;

   typedef enum logic [2:0] {
      CFG_C      = 3'd0,
      CFG_Z      = 3'd1,
      CFG_RSQ    = 3'd2,
      CFG_COLC   = 3'd3,
      CFG_ROWC   = 3'd4,
      CFG_COMMIT = 3'd5
   } cfg_field_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      APPLY   = 2'd2
   } state_e;

   localparam logic [15:0] C_RST = 16'h0000;
   // Largest finite fp16, so an unconfigured zone never rejects on depth.
   localparam logic [15:0] Z_RST = 16'h7BFF;

   // Fields that carry a zone index.
   function automatic logic field_is_zoned(input logic [2:0] field);
      return field <= 3'd2;
   endfunction

endpackage

// File: rtl/radial_cfg_bank.sv
// One bank of zone thresholds plus the radial centre; used as both shadow and active copy.
module radial_cfg_bank
   import radial_cfg_pkg::*;
#(
   parameter int NO_ZONES     = 1,
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 480
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wr_en_i,
   input  logic [2:0]               wr_field_i,
   input  logic [7:0]               wr_zone_i,
   input  logic [17:0]              wr_data_i,
   input  logic                     load_i,
   input  logic [16*NO_ZONES-1:0]   ld_c_i,
   input  logic [16*NO_ZONES-1:0]   ld_z_i,
   input  logic [18*NO_ZONES-1:0]   ld_rsq_i,
   input  logic [15:0]              ld_colc_i,
   input  logic [15:0]              ld_rowc_i,
   output logic [16*NO_ZONES-1:0]   c_o,
   output logic [16*NO_ZONES-1:0]   z_o,
   output logic [18*NO_ZONES-1:0]   r_squared_o,
   output logic [15:0]              col_center_o,
   output logic [15:0]              row_center_o
);

   logic [16*NO_ZONES-1:0] c_q, c_d;
   logic [16*NO_ZONES-1:0] z_q, z_d;
   logic [18*NO_ZONES-1:0] rsq_q, rsq_d;
   logic [15:0]            colc_q, colc_d;
   logic [15:0]            rowc_q, rowc_d;

   // Next bank contents: a parallel load wins over a single-field write.
   always_comb begin
      c_d    = c_q;
      z_d    = z_q;
      rsq_d  = rsq_q;
      colc_d = colc_q;
      rowc_d = rowc_q;
      if (load_i) begin
         c_d    = ld_c_i;
         z_d    = ld_z_i;
         rsq_d  = ld_rsq_i;
         colc_d = ld_colc_i;
         rowc_d = ld_rowc_i;
      end else if (wr_en_i) begin
         case (wr_field_i)
            CFG_C, CFG_Z, CFG_RSQ: begin
               for (int zn = 0; zn < NO_ZONES; zn++) begin
                  if (wr_zone_i == 8'(zn)) begin
                     if (wr_field_i == CFG_C)      c_d[zn*16 +: 16]   = wr_data_i[15:0];
                     else if (wr_field_i == CFG_Z) z_d[zn*16 +: 16]   = wr_data_i[15:0];
                     else                          rsq_d[zn*18 +: 18] = wr_data_i;
                  end
               end
            end
            CFG_COLC: colc_d = wr_data_i[15:0];
            CFG_ROWC: rowc_d = wr_data_i[15:0];
            default:  ;
         endcase
      end
   end

   // Bank registers with synchronous reset to the power-on configuration.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         c_q    <= {NO_ZONES{C_RST}};
         z_q    <= {NO_ZONES{Z_RST}};
         rsq_q  <= '0;
         colc_q <= 16'(FRAME_WIDTH / 2);
         rowc_q <= 16'(FRAME_HEIGHT / 2);
      end else begin
         c_q    <= c_d;
         z_q    <= z_d;
         rsq_q  <= rsq_d;
         colc_q <= colc_d;
         rowc_q <= rowc_d;
      end
   end

   assign c_o          = c_q;
   assign z_o          = z_q;
   assign r_squared_o  = rsq_q;
   assign col_center_o = colc_q;
   assign row_center_o = rowc_q;

endmodule

// File: rtl/radial_zone_cfg_ctrl.sv
// Double-buffered filter configuration: host fills the shadow bank, commits are
// applied to the active bank only at a frame boundary or after the stream idles.
//
// state   | meaning
// IDLE    | accepting config beats into the shadow bank
// PENDING | commit requested, waiting for frame end or idle timeout
// APPLY   | copying shadow to active this cycle
module radial_zone_cfg_ctrl
   import radial_cfg_pkg::*;
#(
   parameter int NO_ZONES     = 1,
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 480,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     cfg_valid_i,
   output logic                     cfg_ready_o,
   input  logic [2:0]               cfg_field_i,
   input  logic [7:0]               cfg_zone_i,
   input  logic [17:0]              cfg_data_i,
   input  logic                     pix_valid_i,
   input  logic [15:0]              pix_col_i,
   input  logic [15:0]              pix_row_i,
   output logic [16*NO_ZONES-1:0]   c_o,
   output logic [16*NO_ZONES-1:0]   z_o,
   output logic [18*NO_ZONES-1:0]   r_squared_o,
   output logic [15:0]              col_center_o,
   output logic [15:0]              row_center_o,
   output logic                     pending_o,
   output logic                     commit_done_o,
   output logic                     cfg_err_o
);

   localparam int            TW       = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'(IDLE_TIMEOUT);

   state_e          state_q, state_d;
   logic [TW-1:0]   idle_cnt_q, idle_cnt_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic            accept, zone_bad, shadow_wr, frame_end, timeout;

   logic [16*NO_ZONES-1:0] sh_c, sh_z;
   logic [18*NO_ZONES-1:0] sh_rsq;
   logic [15:0]            sh_colc, sh_rowc;

   assign accept    = cfg_valid_i && (state_q == IDLE);
   assign zone_bad  = field_is_zoned(cfg_field_i) && ({24'd0, cfg_zone_i} >= 32'(NO_ZONES));
   assign shadow_wr = accept && (cfg_field_i <= 3'd4) && !zone_bad;
   assign frame_end = pix_valid_i && (pix_col_i == 16'(FRAME_WIDTH - 1))
                                  && (pix_row_i == 16'(FRAME_HEIGHT - 1));
   // Down-counter reloads whenever the stream moves, so zero means IDLE_TIMEOUT idle cycles.
   assign timeout   = (IDLE_TIMEOUT != 0) && (idle_cnt_q == '0);

   // Next state, idle timer, error flag and commit pulse.
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      done_d     = (state_q == APPLY);
      err_d      = err_q | (accept && (zone_bad || (cfg_field_i >= 3'd6)));
      case (state_q)
         IDLE:    if (accept && (cfg_field_i == CFG_COMMIT)) state_d = PENDING;
         PENDING: if (frame_end || timeout)                  state_d = APPLY;
         APPLY:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if ((state_q != PENDING) || pix_valid_i) idle_cnt_d = TMO_LOAD;
      else if (idle_cnt_q != '0)               idle_cnt_d = idle_cnt_q - TW'(1);
   end

   // Control registers with synchronous reset; a reset discards any pending commit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         idle_cnt_q <= TMO_LOAD;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idle_cnt_q <= idle_cnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign cfg_ready_o   = (state_q == IDLE);
   assign pending_o     = (state_q == PENDING) || (state_q == APPLY);
   assign commit_done_o = done_q;
   assign cfg_err_o     = err_q;

   radial_cfg_bank #(
      .NO_ZONES     (NO_ZONES),
      .FRAME_WIDTH  (FRAME_WIDTH),
      .FRAME_HEIGHT (FRAME_HEIGHT)
   ) u_shadow (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .wr_en_i      (shadow_wr),
      .wr_field_i   (cfg_field_i),
      .wr_zone_i    (cfg_zone_i),
      .wr_data_i    (cfg_data_i),
      .load_i       (1'b0),
      .ld_c_i       ('0),
      .ld_z_i       ('0),
      .ld_rsq_i     ('0),
      .ld_colc_i    (16'd0),
      .ld_rowc_i    (16'd0),
      .c_o          (sh_c),
      .z_o          (sh_z),
      .r_squared_o  (sh_rsq),
      .col_center_o (sh_colc),
      .row_center_o (sh_rowc)
   );

   radial_cfg_bank #(
      .NO_ZONES     (NO_ZONES),
      .FRAME_WIDTH  (FRAME_WIDTH),
      .FRAME_HEIGHT (FRAME_HEIGHT)
   ) u_active (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .wr_en_i      (1'b0),
      .wr_field_i   (cfg_field_i),
      .wr_zone_i    (cfg_zone_i),
      .wr_data_i    (cfg_data_i),
      .load_i       (state_q == APPLY),
      .ld_c_i       (sh_c),
      .ld_z_i       (sh_z),
      .ld_rsq_i     (sh_rsq),
      .ld_colc_i    (sh_colc),
      .ld_rowc_i    (sh_rowc),
      .c_o          (c_o),
      .z_o          (z_o),
      .r_squared_o  (r_squared_o),
      .col_center_o (col_center_o),
      .row_center_o (row_center_o)
   );

endmodule

// File: tb/tb_radial_zone_cfg_ctrl.sv
// Directed bench for radial_zone_cfg_ctrl on a small 8x4 frame with a 16-cycle idle timeout.
module tb_radial_zone_cfg_ctrl;

   localparam int NZ  = 2;
   localparam int FW  = 8;
   localparam int FH  = 4;
   localparam int TMO = 16;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              cfg_valid_i;
   logic              cfg_ready_o;
   logic [2:0]        cfg_field_i;
   logic [7:0]        cfg_zone_i;
   logic [17:0]       cfg_data_i;
   logic              pix_valid_i;
   logic [15:0]       pix_col_i;
   logic [15:0]       pix_row_i;
   logic [16*NZ-1:0]  c_o;
   logic [16*NZ-1:0]  z_o;
   logic [18*NZ-1:0]  r_squared_o;
   logic [15:0]       col_center_o;
   logic [15:0]       row_center_o;
   logic              pending_o;
   logic              commit_done_o;
   logic              cfg_err_o;

   int   checks   = 0;
   int   failures = 0;
   int   pix_idx  = 0;
   logic stream_en = 1'b0;

   always #5 clk_i = ~clk_i;

   radial_zone_cfg_ctrl #(
      .NO_ZONES     (NZ),
      .FRAME_WIDTH  (FW),
      .FRAME_HEIGHT (FH),
      .IDLE_TIMEOUT (TMO)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .cfg_valid_i   (cfg_valid_i),
      .cfg_ready_o   (cfg_ready_o),
      .cfg_field_i   (cfg_field_i),
      .cfg_zone_i    (cfg_zone_i),
      .cfg_data_i    (cfg_data_i),
      .pix_valid_i   (pix_valid_i),
      .pix_col_i     (pix_col_i),
      .pix_row_i     (pix_row_i),
      .c_o           (c_o),
      .z_o           (z_o),
      .r_squared_o   (r_squared_o),
      .col_center_o  (col_center_o),
      .row_center_o  (row_center_o),
      .pending_o     (pending_o),
      .commit_done_o (commit_done_o),
      .cfg_err_o     (cfg_err_o)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_pix();
      pix_valid_i = stream_en;
      pix_col_i   = 16'(pix_idx % FW);
      pix_row_i   = 16'(pix_idx / FW);
   endtask

   // Advance one clock; outputs are sampled 1 ns after the edge, inputs change there too.
   task automatic tick();
      @(posedge clk_i);
      #1;
      if (stream_en) pix_idx = (pix_idx + 1) % (FW * FH);
      drive_pix();
   endtask

   task automatic start_stream(input int idx);
      pix_idx   = idx;
      stream_en = 1'b1;
      drive_pix();
   endtask

   task automatic stop_stream();
      stream_en = 1'b0;
      drive_pix();
   endtask

   task automatic cfg_write(input logic [2:0] f, input logic [7:0] zn, input logic [17:0] d);
      int n;
      cfg_valid_i = 1'b1;
      cfg_field_i = f;
      cfg_zone_i  = zn;
      cfg_data_i  = d;
      n = 0;
      while (!cfg_ready_o && n < 200) begin
         tick();
         n++;
      end
      check_val("cfg_accept_bound", 64'(n < 200), 64'd1);
      tick();
      cfg_valid_i = 1'b0;
   endtask

   task automatic wait_done(output int k, input int limit);
      k = 0;
      do begin
         tick();
         k++;
      end while (!commit_done_o && k < limit);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_val({pfx, "_c"},       64'(c_o),          64'h0);
      check_val({pfx, "_z"},       64'(z_o),          64'h7BFF7BFF);
      check_val({pfx, "_rsq"},     64'(r_squared_o),  64'h0);
      check_val({pfx, "_colc"},    64'(col_center_o), 64'd4);
      check_val({pfx, "_rowc"},    64'(row_center_o), 64'd2);
      check_val({pfx, "_pending"}, 64'(pending_o),    64'd0);
      check_val({pfx, "_done"},    64'(commit_done_o),64'd0);
      check_val({pfx, "_ready"},   64'(cfg_ready_o),  64'd1);
   endtask

   initial begin
      int   k;
      logic early;
      rst_i       = 1'b1;
      cfg_valid_i = 1'b0;
      cfg_field_i = 3'd0;
      cfg_zone_i  = 8'd0;
      cfg_data_i  = 18'd0;
      drive_pix();

      // Reset state
      do_reset();
      check_reset_outputs("rst");
      check_val("rst_err", 64'(cfg_err_o), 64'd0);

      // Frame-end commit with a continuous stream
      cfg_write(3'd0, 8'd0, 18'h03800);
      cfg_write(3'd1, 8'd0, 18'h04400);
      cfg_write(3'd2, 8'd0, 18'd10000);
      cfg_write(3'd0, 8'd1, 18'h03C00);
      cfg_write(3'd3, 8'd0, 18'd3);
      cfg_write(3'd4, 8'd0, 18'd1);
      check_val("shadow_only_c", 64'(c_o), 64'h0);
      start_stream(0);
      cfg_write(3'd5, 8'd0, 18'd0);
      early = 1'b0;
      k = 0;
      do begin
         tick();
         k++;
         if (!commit_done_o && c_o !== 32'h0) early = 1'b1;
      end while (!commit_done_o && k < 100);
      check_val("fe_latency", 64'(k), 64'd32);
      check_val("fe_no_early_change", 64'(early), 64'd0);
      check_val("fe_c",       64'(c_o),          64'h3C003800);
      check_val("fe_z",       64'(z_o),          64'h7BFF4400);
      check_val("fe_rsq",     64'(r_squared_o),  {28'd0, 18'd0, 18'd10000});
      check_val("fe_colc",    64'(col_center_o), 64'd3);
      check_val("fe_rowc",    64'(row_center_o), 64'd1);
      check_val("fe_pending", 64'(pending_o),    64'd0);
      check_val("fe_ready",   64'(cfg_ready_o),  64'd1);
      tick();
      check_val("fe_done_pulse", 64'(commit_done_o), 64'd0);
      stop_stream();

      // Idle-timeout commit with the stream halted
      cfg_write(3'd2, 8'd1, 18'h3FFFF);
      cfg_write(3'd5, 8'd0, 18'd0);
      check_val("tmo_pending", 64'(pending_o),   64'd1);
      check_val("tmo_ready",   64'(cfg_ready_o), 64'd0);
      wait_done(k, 100);
      check_val("tmo_latency", 64'(k), 64'd18);
      check_val("tmo_rsq", 64'(r_squared_o), {28'd0, 18'h3FFFF, 18'd10000});
      check_val("tmo_c",   64'(c_o),         64'h3C003800);

      // Commit accepted on the frame-end pixel waits a full frame
      cfg_write(3'd0, 8'd0, 18'h05555);
      start_stream(FW * FH - 1);
      cfg_write(3'd5, 8'd0, 18'd0);
      wait_done(k, 100);
      check_val("coinc_latency", 64'(k), 64'd33);
      check_val("coinc_c", 64'(c_o), 64'h3C005555);
      stop_stream();

      // Error handling: reserved field and out-of-range zone
      do_reset();
      check_reset_outputs("rst2");
      cfg_write(3'd7, 8'd0, 18'h00003);
      check_val("err_rsvd", 64'(cfg_err_o), 64'd1);
      do_reset();
      check_val("err_cleared", 64'(cfg_err_o), 64'd0);
      cfg_write(3'd0, 8'(NZ), 18'h0DEAD);
      check_val("err_zone", 64'(cfg_err_o), 64'd1);
      cfg_write(3'd2, 8'hFF, 18'h00005);
      cfg_write(3'd6, 8'd0, 18'h00009);
      cfg_write(3'd5, 8'd0, 18'd0);
      wait_done(k, 100);
      check_val("err_commit_latency", 64'(k), 64'd18);
      check_val("err_c",    64'(c_o),          64'h0);
      check_val("err_z",    64'(z_o),          64'h7BFF7BFF);
      check_val("err_rsq",  64'(r_squared_o),  64'h0);
      check_val("err_colc", 64'(col_center_o), 64'd4);
      check_val("err_rowc", 64'(row_center_o), 64'd2);
      check_val("err_sticky", 64'(cfg_err_o),  64'd1);

      // Beat held during PENDING is only taken after return to IDLE
      cfg_write(3'd5, 8'd0, 18'd0);
      cfg_valid_i = 1'b1;
      cfg_field_i = 3'd0;
      cfg_zone_i  = 8'd0;
      cfg_data_i  = 18'h01111;
      tick();
      check_val("hold_ready_low", 64'(cfg_ready_o), 64'd0);
      k = 1;
      while (!cfg_ready_o && k < 100) begin
         tick();
         k++;
      end
      check_val("hold_ready_return", 64'(k), 64'd18);
      check_val("hold_done_same", 64'(commit_done_o), 64'd1);
      check_val("hold_not_written", 64'(c_o), 64'h0);
      tick();
      cfg_valid_i = 1'b0;
      cfg_write(3'd5, 8'd0, 18'd0);
      wait_done(k, 100);
      check_val("hold_written_c", 64'(c_o), 64'h00001111);

      // Reset in the middle of PENDING discards the commit
      cfg_write(3'd0, 8'd0, 18'h02222);
      start_stream(0);
      cfg_write(3'd5, 8'd0, 18'd0);
      tick();
      tick();
      check_val("rstp_pending", 64'(pending_o), 64'd1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check_reset_outputs("rstp");
      early = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (commit_done_o) early = 1'b1;
      end
      check_val("rstp_no_done", 64'(early), 64'd0);
      check_val("rstp_c_after", 64'(c_o), 64'h0);
      check_val("rstp_pending_after", 64'(pending_o), 64'd0);
      stop_stream();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
